button_event_classifier: RTL and testbench



---
 rtl/btn_pkg.sv | 14 +
 rtl/edge_detect.sv | 19 +
 rtl/button_event_classifier.sv | 115 +++++++++++
 tb/tb_button_event_classifier.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button gesture logic and the 10 ms tick generator.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HELD1,
        GAP,
        HOLD_LONG,
        WAIT_REL
    } btn_state_t;

    localparam int TICK_PERIOD_MS = 10;

endpackage

// File: rtl/edge_detect.sv
// One-register edge detector on the debounced level; rise/fall are combinational.
// db_q keeps loading db during reset so a level held across reset is not seen as a press.
module edge_detect (
    input  logic clk,
    input  logic db,
    output logic rise,
    output logic fall
);

    logic db_q;

    always_ff @(posedge clk) begin
        db_q <= db;
    end

    assign rise = db & ~db_q;
    assign fall = ~db & db_q;

endmodule

// File: rtl/button_event_classifier.sv
// Classifies single/double/long/repeat gestures from the debounced level, timed in ticks.
// Event pulses are registered: high for one clk after the edge that sampled the condition.
module button_event_classifier
    import btn_pkg::*;
#(
    parameter int LONG_TICKS   = 100,
    parameter int GAP_TICKS    = 30,
    parameter int REPEAT_TICKS = 20,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    input  logic tick,
    output logic single_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_press,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = (REPEAT_TICKS == 0) ? '0 : CNT_W'(REPEAT_TICKS - 1);
    localparam bit               REP_EN    = (REPEAT_TICKS != 0);

    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             rep_hit;
    logic             rise;
    logic             fall;
    logic             single_nxt;
    logic             double_nxt;
    logic             long_nxt;
    logic             repeat_nxt;

    edge_detect u_edge (
        .clk  (clk),
        .db   (db),
        .rise (rise),
        .fall (fall)
    );

    // Edges are tested before tick expiry so an edge always wins a same-cycle tie.
    always_comb begin
        state_nxt  = state;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        rep_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_nxt = HELD1;
            end
            HELD1: begin
                if (fall) begin
                    state_nxt = GAP;
                end else if (tick && cnt == LONG_LAST) begin
                    long_nxt  = 1'b1;
                    state_nxt = HOLD_LONG;
                end
            end
            GAP: begin
                if (rise) begin
                    double_nxt = 1'b1;
                    state_nxt  = WAIT_REL;
                end else if (tick && cnt == GAP_LAST) begin
                    single_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            HOLD_LONG: begin
                if (fall) begin
                    state_nxt = IDLE;
                end else if (REP_EN && tick && cnt == REP_LAST) begin
                    repeat_nxt = 1'b1;
                    rep_hit    = 1'b1;
                end
            end
            WAIT_REL: begin
                if (fall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        cnt_clr = (state_nxt != state) || rep_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            single_press <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            single_press <= single_nxt;
            double_press <= double_nxt;
            long_press   <= long_nxt;
            repeat_press <= repeat_nxt;
            busy         <= (state_nxt != IDLE);
            if (cnt_clr) begin
                cnt <= '0;
            end else if (tick && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_event_classifier.sv
// Bench for button_event_classifier: one instance with repeat enabled, one with repeat disabled.
module tb_button_event_classifier;

    localparam int LONG = 5;
    localparam int GAPT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic db = 1'b0;
    logic tick = 1'b0;
    int   phase = 0;

    logic s0, d0, l0, r0, b0;
    logic s1, d1, l1, r1, b1;
    logic [4:0] obs0, obs1;
    assign obs0 = {s0, d0, l0, r0, b0};
    assign obs1 = {s1, d1, l1, r1, b1};

    always #5 clk = ~clk;

    button_event_classifier #(.LONG_TICKS(LONG), .GAP_TICKS(GAPT), .REPEAT_TICKS(2), .CNT_W(8)) dut_rep (
        .clk(clk), .reset(reset), .db(db), .tick(tick),
        .single_press(s0), .double_press(d0), .long_press(l0), .repeat_press(r0), .busy(b0)
    );

    button_event_classifier #(.LONG_TICKS(LONG), .GAP_TICKS(GAPT), .REPEAT_TICKS(0), .CNT_W(8)) dut_norep (
        .clk(clk), .reset(reset), .db(db), .tick(tick),
        .single_press(s1), .double_press(d1), .long_press(l1), .repeat_press(r1), .busy(b1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: gesture phase flags plus tick timestamps (ticks elapsed since last mark).
    int       ticks_seen = 0;
    bit       prev_db = 1'b0;
    bit       m_act[2], m_held[2], m_gap[2], m_long[2], m_sec[2];
    int       m_mark[2];
    logic [4:0] m_exp[2];

    int n_s[2], n_d[2], n_l[2], n_r[2];
    int bad_cycles;
    logic [4:0] bad_got, bad_want;
    int bad_inst;
    time bad_t;

    task automatic model_step();
        bit rs, fl;
        if (tick) ticks_seen++;
        if (reset) begin
            prev_db = db;
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 0; m_held[k] = 0; m_gap[k] = 0; m_long[k] = 0; m_sec[k] = 0;
                m_exp[k] = 5'b0;
            end
            return;
        end
        rs = db && !prev_db;
        fl = !db && prev_db;
        prev_db = db;
        for (int k = 0; k < 2; k++) begin
            bit es, ed, el, er;
            int rep;
            rep = (k == 0) ? 2 : 0;
            es = 0; ed = 0; el = 0; er = 0;
            if (!m_act[k]) begin
                if (rs) begin m_act[k] = 1; m_held[k] = 1; m_mark[k] = ticks_seen; end
            end else if (m_held[k]) begin
                if (fl) begin
                    m_held[k] = 0; m_gap[k] = 1; m_mark[k] = ticks_seen;
                end else if (tick && ticks_seen - m_mark[k] == LONG) begin
                    m_held[k] = 0; m_long[k] = 1; el = 1; m_mark[k] = ticks_seen;
                end
            end else if (m_gap[k]) begin
                if (rs) begin
                    m_gap[k] = 0; m_sec[k] = 1; ed = 1;
                end else if (tick && ticks_seen - m_mark[k] == GAPT) begin
                    m_gap[k] = 0; m_act[k] = 0; es = 1;
                end
            end else if (m_long[k]) begin
                if (fl) begin
                    m_long[k] = 0; m_act[k] = 0;
                end else if (rep != 0 && tick && ticks_seen - m_mark[k] == rep) begin
                    er = 1; m_mark[k] = ticks_seen;
                end
            end else if (m_sec[k]) begin
                if (fl) begin m_sec[k] = 0; m_act[k] = 0; end
            end
            m_exp[k] = {es, ed, el, er, m_act[k]};
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            n_s[k] = 0; n_d[k] = 0; n_l[k] = 0; n_r[k] = 0;
        end
        bad_cycles = 0;
    endtask

    // Drive one clk of stimulus, advance the model, and tally observed pulses.
    task automatic cycle(input bit d);
        logic [4:0] got;
        db = d;
        tick = (phase == 0);
        phase = (phase + 1) % 4;
        @(posedge clk);
        #1;
        model_step();
        for (int k = 0; k < 2; k++) begin
            got = (k == 0) ? obs0 : obs1;
            n_s[k] += int'(got[4]); n_d[k] += int'(got[3]);
            n_l[k] += int'(got[2]); n_r[k] += int'(got[1]);
            if (got !== m_exp[k]) begin
                if (bad_cycles == 0) begin
                    bad_got = got; bad_want = m_exp[k]; bad_inst = k; bad_t = $time;
                end
                bad_cycles++;
            end
        end
    endtask

    task automatic hold_ticks(input bit lvl, input int n);
        int seen = 0;
        while (seen < n) begin
            cycle(lvl);
            if (tick) seen++;
        end
    endtask

    // Hold lvl, then drive at_lvl on exactly the cycle carrying the n-th tick.
    task automatic run_to_tick(input bit lvl, input int n, input bit at_lvl);
        int seen = 0;
        while (1) begin
            if (phase == 0 && seen == n - 1) begin
                cycle(at_lvl);
                break;
            end
            cycle(lvl);
            if (tick) seen++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic test_reset();
        clear_stats();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0);
        vectors++;
        if ({obs0, obs1} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want %b", {obs0, obs1}, 10'b0);
        end
        reset = 1'b0;
        idle(3);
        vectors++;
        if (bad_cycles != 0) begin
            miscompares++;
            $display("FAIL reset_model inst%0d t=%0t got %b want %b", bad_inst, bad_t, bad_got, bad_want);
        end
    endtask

    task automatic test_short();
        clear_stats();
        idle($urandom_range(1, 6));
        cycle(1'b1);
        hold_ticks(1'b1, $urandom_range(1, 3));
        hold_ticks(1'b0, 6);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (n_s[k] !== 1 || n_d[k] + n_l[k] + n_r[k] !== 0) begin
                miscompares++;
                $display("FAIL short_counts inst%0d got s=%0d other=%0d want s=1 other=0", k, n_s[k], n_d[k] + n_l[k] + n_r[k]);
            end
        end
        vectors++;
        if (bad_cycles != 0 || b0 !== 1'b0) begin
            miscompares++;
            $display("FAIL short_model inst%0d t=%0t got %b want %b busy=%b", bad_inst, bad_t, bad_got, bad_want, b0);
        end
    endtask

    task automatic test_double();
        clear_stats();
        idle($urandom_range(1, 6));
        cycle(1'b1);
        hold_ticks(1'b1, 1);
        hold_ticks(1'b0, $urandom_range(1, 2));
        hold_ticks(1'b1, $urandom_range(1, 8));
        hold_ticks(1'b0, 6);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (n_d[k] !== 1 || n_s[k] + n_l[k] + n_r[k] !== 0) begin
                miscompares++;
                $display("FAIL double_counts inst%0d got d=%0d other=%0d want d=1 other=0", k, n_d[k], n_s[k] + n_l[k] + n_r[k]);
            end
        end
        vectors++;
        if (bad_cycles != 0) begin
            miscompares++;
            $display("FAIL double_model inst%0d t=%0t got %b want %b", bad_inst, bad_t, bad_got, bad_want);
        end
    endtask

    task automatic test_long_repeat();
        clear_stats();
        idle($urandom_range(1, 6));
        cycle(1'b1);
        hold_ticks(1'b1, 12);
        hold_ticks(1'b0, 6);
        vectors++;
        if (n_l[0] !== 1 || n_r[0] !== 3 || n_s[0] + n_d[0] !== 0) begin
            miscompares++;
            $display("FAIL long_repeat got l=%0d r=%0d sd=%0d want l=1 r=3 sd=0", n_l[0], n_r[0], n_s[0] + n_d[0]);
        end
        vectors++;
        if (n_l[1] !== 1 || n_r[1] !== 0 || n_s[1] + n_d[1] !== 0) begin
            miscompares++;
            $display("FAIL long_norepeat got l=%0d r=%0d sd=%0d want l=1 r=0 sd=0", n_l[1], n_r[1], n_s[1] + n_d[1]);
        end
        vectors++;
        if (bad_cycles != 0 || {b0, b1} !== 2'b00) begin
            miscompares++;
            $display("FAIL long_model inst%0d t=%0t got %b want %b", bad_inst, bad_t, bad_got, bad_want);
        end
    endtask

    task automatic test_ties();
        clear_stats();
        idle($urandom_range(1, 6));
        cycle(1'b1);
        run_to_tick(1'b1, LONG, 1'b0);
        hold_ticks(1'b0, 6);
        vectors++;
        if (n_l[0] + n_l[1] !== 0 || n_s[0] !== 1 || n_s[1] !== 1) begin
            miscompares++;
            $display("FAIL tie_release_long got l=%0d s=%0d/%0d want l=0 s=1/1", n_l[0] + n_l[1], n_s[0], n_s[1]);
        end
        clear_stats();
        idle($urandom_range(1, 6));
        cycle(1'b1);
        hold_ticks(1'b1, 1);
        cycle(1'b0);
        run_to_tick(1'b0, GAPT, 1'b1);
        hold_ticks(1'b1, 2);
        hold_ticks(1'b0, 6);
        vectors++;
        if (n_s[0] + n_s[1] !== 0 || n_d[0] !== 1 || n_d[1] !== 1) begin
            miscompares++;
            $display("FAIL tie_rise_gap got s=%0d d=%0d/%0d want s=0 d=1/1", n_s[0] + n_s[1], n_d[0], n_d[1]);
        end
        vectors++;
        if (bad_cycles != 0) begin
            miscompares++;
            $display("FAIL tie_model inst%0d t=%0t got %b want %b", bad_inst, bad_t, bad_got, bad_want);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        idle(3);
        cycle(1'b1);
        hold_ticks(1'b1, 2);
        reset = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        vectors++;
        if ({obs0, obs1} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_held1_outputs got %b want %b", {obs0, obs1}, 10'b0);
        end
        reset = 1'b0;
        hold_ticks(1'b1, 1);
        hold_ticks(1'b0, 8);
        cycle(1'b1);
        hold_ticks(1'b1, 1);
        cycle(1'b0);
        hold_ticks(1'b0, 1);
        reset = 1'b1;
        cycle(1'b0);
        reset = 1'b0;
        hold_ticks(1'b0, 6);
        vectors++;
        if (n_s[0] + n_d[0] + n_l[0] + n_r[0] + n_s[1] + n_d[1] + n_l[1] + n_r[1] !== 0) begin
            miscompares++;
            $display("FAIL reset_suppress got s=%0d d=%0d l=%0d want all 0", n_s[0] + n_s[1], n_d[0] + n_d[1], n_l[0] + n_l[1]);
        end
        clear_stats();
        cycle(1'b1);
        reset = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        reset = 1'b0;
        hold_ticks(1'b1, 8);
        vectors++;
        if (n_l[0] + n_l[1] !== 0 || {b0, b1} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_held_through got l=%0d busy=%b want l=0 busy=00", n_l[0] + n_l[1], {b0, b1});
        end
        hold_ticks(1'b0, 6);
        cycle(1'b1);
        hold_ticks(1'b1, 1);
        hold_ticks(1'b0, 6);
        vectors++;
        if (n_s[0] !== 1 || n_s[1] !== 1 || n_l[0] + n_l[1] !== 0) begin
            miscompares++;
            $display("FAIL reset_new_rise got s=%0d/%0d l=%0d want s=1/1 l=0", n_s[0], n_s[1], n_l[0] + n_l[1]);
        end
        vectors++;
        if (bad_cycles != 0) begin
            miscompares++;
            $display("FAIL reset_mid_model inst%0d t=%0t got %b want %b", bad_inst, bad_t, bad_got, bad_want);
        end
    endtask

    task automatic test_random();
        clear_stats();
        for (int g = 0; g < 60; g++) begin
            int hi, lo;
            hi = $urandom_range(1, 60);
            lo = $urandom_range(1, 20);
            for (int i = 0; i < hi; i++) cycle(1'b1);
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                cycle($urandom_range(0, 1) == 1);
                reset = 1'b0;
            end
            for (int i = 0; i < lo; i++) cycle(1'b0);
        end
        hold_ticks(1'b0, 6);
        vectors++;
        if (bad_cycles != 0) begin
            miscompares++;
            $display("FAIL random_model inst%0d t=%0t got %b want %b", bad_inst, bad_t, bad_got, bad_want);
        end
        vectors++;
        if (n_s[0] + n_d[0] + n_l[0] == 0) begin
            miscompares++;
            $display("FAIL random_activity got events=%0d want >0", n_s[0] + n_d[0] + n_l[0]);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_short();
        test_double();
        test_double();
        test_long_repeat();
        test_ties();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
